// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: per-source writeback FIFOs (ALU, LSU) drained
// round-robin into a registered register-file write port.

module regfile_wb_fifo #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_data,
    output logic            ready,
    output logic            nonempty,
    output logic [4:0]      head_rd,
    output logic [XLEN-1:0] head_data,
    output logic [31:0]     mask
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CW-1:0]   count;

    // ready comes from the registered count only, so a full FIFO
    // refuses a push even in a cycle where it also pops
    assign ready     = (count != CW'(DEPTH));
    assign nonempty  = (count != '0);
    assign head_rd   = mem_rd[rptr];
    assign head_data = mem_data[rptr];

    // storage is only ever read behind count, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wptr]   <= in_rd;
            mem_data[wptr] <= in_data;
        end
    end

    // pointers wrap modulo DEPTH; push+pop leaves count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // one-hot OR of the destination of every live entry
    always_comb begin
        logic [AW-1:0] idx;
        mask = '0;
        idx  = '0;
        for (int j = 0; j < DEPTH; j++) begin
            idx = rptr + AW'(j);
            if (CW'(j) < count)
                mask[mem_rd[idx]] = 1'b1;
        end
    end
endmodule

module regfile_wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending,
    output logic            idle
);
    logic            alu_push;
    logic            lsu_push;
    logic            alu_ne;
    logic            lsu_ne;
    logic            gnt_alu;
    logic            gnt_lsu;
    logic            rr_lsu;
    logic [4:0]      alu_hrd;
    logic [4:0]      lsu_hrd;
    logic [XLEN-1:0] alu_hdata;
    logic [XLEN-1:0] lsu_hdata;
    logic [31:0]     alu_mask;
    logic [31:0]     lsu_mask;

    // x0 writes finish the handshake but are never queued
    assign alu_push = alu_valid && alu_ready && (alu_rd != 5'd0);
    assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

    assign gnt_alu = alu_ne && (!lsu_ne || !rr_lsu);
    assign gnt_lsu = lsu_ne && !gnt_alu;

    regfile_wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (alu_push),
        .pop       (gnt_alu),
        .in_rd     (alu_rd),
        .in_data   (alu_data),
        .ready     (alu_ready),
        .nonempty  (alu_ne),
        .head_rd   (alu_hrd),
        .head_data (alu_hdata),
        .mask      (alu_mask)
    );

    regfile_wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_lsu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lsu_push),
        .pop       (gnt_lsu),
        .in_rd     (lsu_rd),
        .in_data   (lsu_data),
        .ready     (lsu_ready),
        .nonempty  (lsu_ne),
        .head_rd   (lsu_hrd),
        .head_data (lsu_hdata),
        .mask      (lsu_mask)
    );

    // pointer only moves on contention, handing priority to the loser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_lsu <= 1'b0;
        else if (alu_ne && lsu_ne)
            rr_lsu <= gnt_alu;
    end

    // registered write port; address/data hold when nothing pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= gnt_alu || gnt_lsu;
            unique case (1'b1)
                gnt_alu: begin
                    rf_rd    <= alu_hrd;
                    rf_wdata <= alu_hdata;
                end
                gnt_lsu: begin
                    rf_rd    <= lsu_hrd;
                    rf_wdata <= lsu_hdata;
                end
                default: ;
            endcase
        end
    end

    // pending covers both queues plus the write in flight on the port
    always_comb begin
        pending = alu_mask | lsu_mask;
        if (rf_we)
            pending[rf_rd] = 1'b1;
    end

    assign idle = !alu_ne && !lsu_ne && !rf_we;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed stimulus with immediate assertions
// against hand-computed writeback order, latency and pending mask.

module tb_regfile_wb_arbiter;
    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [63:0] rf_wdata;
    logic [31:0] pending;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [4:0]  q_rd   [$];
    logic [63:0] q_data [$];
    int          q_cyc  [$];

    regfile_wb_arbiter #(.XLEN(64), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .pending   (pending),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // log every register-file write seen on the port
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            q_rd.push_back(rf_rd);
            q_data.push_back(rf_wdata);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] lrd(input int i);
        if (i < q_rd.size()) return 64'(q_rd[i]);
        return 64'h1f;
    endfunction

    function automatic logic [63:0] ldat(input int i);
        if (i < q_data.size()) return q_data[i];
        return '1;
    endfunction

    function automatic int lcyc(input int i);
        if (i < q_cyc.size()) return q_cyc[i];
        return -1000;
    endfunction

    task automatic clear_log();
        q_rd.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    initial begin
        int ai;
        int li;
        int n;
        bit af;
        bit lf;
        bit saw_a;
        bit saw_l;

        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_we",    64'(rf_we), 64'd0);
        chk("rst_rd",    64'(rf_rd), 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_pend",  64'(pending), 64'd0);
        chk("rst_idle",  64'(idle), 64'd1);
        chk("rst_ardy",  64'(alu_ready), 64'd1);
        chk("rst_lrdy",  64'(lsu_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single ALU write
        clear_log();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD_BEEF;
        chk("t1_ardy", 64'(alu_ready), 64'd1);
        @(negedge clk);
        alu_valid = 1'b0;
        chk("t1_pend_q", 64'(pending[5]), 64'd1);
        chk("t1_we_early", 64'(rf_we), 64'd0);
        @(negedge clk);
        chk("t1_we", 64'(rf_we), 64'd1);
        chk("t1_rd", 64'(rf_rd), 64'd5);
        chk("t1_wdata", rf_wdata, 64'hDEAD_BEEF);
        chk("t1_pend_w", 64'(pending[5]), 64'd1);
        @(negedge clk);
        chk("t1_we_end", 64'(rf_we), 64'd0);
        chk("t1_pend_end", 64'(pending), 64'd0);
        chk("t1_idle", 64'(idle), 64'd1);
        chk("t1_nwr", 64'(q_rd.size()), 64'd1);

        // 2: LSU write to x0 is dropped
        clear_log();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'h1234;
        chk("t2_lrdy0", 64'(lsu_ready), 64'd1);
        @(negedge clk);
        lsu_valid = 1'b0;
        chk("t2_lrdy1", 64'(lsu_ready), 64'd1);
        chk("t2_pend1", 64'(pending), 64'd0);
        chk("t2_idle1", 64'(idle), 64'd1);
        repeat (2) @(negedge clk);
        chk("t2_we", 64'(rf_we), 64'd0);
        chk("t2_pend2", 64'(pending), 64'd0);
        chk("t2_idle2", 64'(idle), 64'd1);
        chk("t2_nwr", 64'(q_rd.size()), 64'd0);

        // 3: simultaneous single pushes, ALU first
        clear_log();
        alu_valid = 1'b1; alu_rd = 5'd1;  alu_data = 64'h101;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 64'h20B;
        @(negedge clk);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        chk("t3_pend", 64'(pending), 64'h0000_0802);
        repeat (3) @(negedge clk);
        chk("t3_nwr", 64'(q_rd.size()), 64'd2);
        chk("t3_rd0", lrd(0), 64'd1);
        chk("t3_d0", ldat(0), 64'h101);
        chk("t3_rd1", lrd(1), 64'd11);
        chk("t3_d1", ldat(1), 64'h20B);
        chk("t3_back2back", 64'(lcyc(1) - lcyc(0)), 64'd1);

        // 4: both sources streaming, pointer starts at ALU
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        ai = 1; li = 11; n = 0; saw_a = 1'b0; saw_l = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'(ai); alu_data = 64'(256 + ai);
        lsu_valid = 1'b1; lsu_rd = 5'(li); lsu_data = 64'(512 + li);
        while ((alu_valid || lsu_valid) && n < 60) begin
            af = alu_valid && alu_ready;
            lf = lsu_valid && lsu_ready;
            if (!alu_ready) saw_a = 1'b1;
            if (!lsu_ready) saw_l = 1'b1;
            @(negedge clk);
            n++;
            if (af) begin
                ai++;
                if (ai > 8) alu_valid = 1'b0;
                else begin
                    alu_rd = 5'(ai);
                    alu_data = 64'(256 + ai);
                end
            end
            if (lf) begin
                li++;
                if (li > 18) lsu_valid = 1'b0;
                else begin
                    lsu_rd = 5'(li);
                    lsu_data = 64'(512 + li);
                end
            end
        end
        chk("t4_budget", 64'(alu_valid || lsu_valid), 64'd0);
        repeat (6) @(negedge clk);
        chk("t4_ardy_drop", 64'(saw_a), 64'd1);
        chk("t4_lrdy_drop", 64'(saw_l), 64'd1);
        chk("t4_nwr", 64'(q_rd.size()), 64'd16);
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) begin
                chk($sformatf("t4_rd%0d", k), lrd(k), 64'(1 + k / 2));
                chk($sformatf("t4_d%0d", k), ldat(k), 64'(257 + k / 2));
            end else begin
                chk($sformatf("t4_rd%0d", k), lrd(k), 64'(11 + k / 2));
                chk($sformatf("t4_d%0d", k), ldat(k), 64'(523 + k / 2));
            end
        end
        chk("t4_rate", 64'(lcyc(15) - lcyc(0)), 64'd15);
        chk("t4_idle", 64'(idle), 64'd1);

        // 5: back-to-back ALU writes to x7
        clear_log();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hA;
        @(negedge clk);
        chk("t5_pend0", 64'(pending[7]), 64'd1);
        chk("t5_ardy", 64'(alu_ready), 64'd1);
        alu_data = 64'hB;
        @(negedge clk);
        alu_valid = 1'b0;
        chk("t5_we_a", 64'(rf_we), 64'd1);
        chk("t5_rd_a", 64'(rf_rd), 64'd7);
        chk("t5_wd_a", rf_wdata, 64'hA);
        chk("t5_pend_a", 64'(pending[7]), 64'd1);
        @(negedge clk);
        chk("t5_we_b", 64'(rf_we), 64'd1);
        chk("t5_wd_b", rf_wdata, 64'hB);
        chk("t5_pend_b", 64'(pending[7]), 64'd1);
        @(negedge clk);
        chk("t5_we_end", 64'(rf_we), 64'd0);
        chk("t5_pend_end", 64'(pending[7]), 64'd0);
        chk("t5_nwr", 64'(q_rd.size()), 64'd2);

        // 6: reset in the middle of a drain
        alu_valid = 1'b1; alu_rd = 5'd2;  alu_data = 64'h22;
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 64'h2C;
        @(negedge clk);
        alu_rd = 5'd3; alu_data = 64'h33;
        lsu_valid = 1'b0;
        @(negedge clk);
        alu_valid = 1'b0;
        chk("t6_busy_we", 64'(rf_we), 64'd1);
        chk("t6_busy_idle", 64'(idle), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        clear_log();
        chk("t6_rst_we", 64'(rf_we), 64'd0);
        chk("t6_rst_pend", 64'(pending), 64'd0);
        chk("t6_rst_ardy", 64'(alu_ready), 64'd1);
        chk("t6_rst_lrdy", 64'(lsu_ready), 64'd1);
        chk("t6_rst_idle", 64'(idle), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_nwr", 64'(q_rd.size()), 64'd0);
        chk("t6_pend_after", 64'(pending), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
